// File: rtl/cnt_pkg.sv
// Shared definitions for the count expander: default sizes, FSM state
// encoding and the count clamp used when a word is accepted.
package cnt_pkg;

    localparam int GROUP_DEF = 5;
    localparam int CW_DEF    = 3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Limit a ones-count to the group size so an illegal word becomes an
    // all-ones group instead of an undefined pattern.
    function automatic int unsigned clamp_count(input int unsigned count,
                                                input int unsigned group);
        return (count > group) ? group : count;
    endfunction

endpackage

// File: rtl/cnt_therm_dec.sv
// Combinational thermometer decoder: bit i is set when i < count.
module cnt_therm_dec #(
    parameter int GROUP = 5,
    parameter int CW    = 3
) (
    input  logic [CW-1:0]    count,
    output logic [GROUP-1:0] therm
);

    for (genvar g = 0; g < GROUP; g++) begin : g_bit
        assign therm[g] = (count > CW'(g));
    end

endmodule

// File: rtl/count_expander.sv
// count_expander: turns a 3-bit ones-count word into a canonical unary
// group of GROUP bits, serialized ones first, with valid/ready on both sides
// and no bubble between consecutive groups.
// Optional macro CNT_EXPAND_THERM_EN adds therm_o, the thermometer of the
// most recently accepted (clamped) count.
module count_expander
    import cnt_pkg::*;
#(
    parameter int GROUP = GROUP_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_bit,
    output logic          out_last,
    output logic          err_illegal
`ifdef CNT_EXPAND_THERM_EN
    ,
    output logic [GROUP-1:0] therm_o
`endif
);

    localparam int IW = (GROUP > 1) ? $clog2(GROUP) : 1;

    state_t           state;
    state_t           state_next;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt_q;
    logic [GROUP-1:0] therm;
    logic             in_hs;
    logic             out_hs;
    logic             at_last;

    cnt_therm_dec #(
        .GROUP (GROUP),
        .CW    (CW)
    ) u_dec (
        .count (cnt_q),
        .therm (therm)
    );

`ifdef CNT_EXPAND_THERM_EN
    assign therm_o = therm;
`endif

    // Handshake decode, outputs and next state; in_ready looks at out_ready
    // so the next word can load on the same edge the last bit leaves.
    always_comb begin
        state_next = state;
        at_last    = (idx == IW'(GROUP - 1));
        out_valid  = (state == EMIT);
        out_bit    = (state == EMIT) & therm[idx];
        out_last   = (state == EMIT) & at_last;
        in_ready   = (state == IDLE) | ((state == EMIT) & at_last & out_ready);
        in_hs      = in_valid & in_ready;
        out_hs     = out_valid & out_ready;
        case (state)
            IDLE: begin
                if (in_hs) state_next = EMIT;
            end
            EMIT: begin
                if (out_hs && at_last && !in_hs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset drops any group in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Count and bit index: load on accept, advance on each delivered bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx   <= '0;
        end else if (in_hs) begin
            cnt_q <= CW'(clamp_count(32'(in_count), GROUP));
            idx   <= '0;
        end else if (out_hs && !at_last) begin
            idx <= idx + IW'(1);
        end
    end

    // One-cycle flag for an accepted word that had to be clamped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_illegal <= 1'b0;
        else        err_illegal <= in_hs & (in_count > CW'(GROUP));
    end

endmodule

// File: tb/tb_count_expander.sv
// Self-checking bench for count_expander. Expected {bit,last} pairs are
// queued when a word is offered and compared as the DUT delivers bits.
module tb_count_expander;

    localparam int GROUP = 5;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_count = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_bit;
    logic          out_last;
    logic          err_illegal;
`ifdef CNT_EXPAND_THERM_EN
    logic [GROUP-1:0] therm_o;
`endif

    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    count_expander #(.GROUP(GROUP), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_count    (in_count),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bit     (out_bit),
        .out_last    (out_last),
        .err_illegal (err_illegal)
`ifdef CNT_EXPAND_THERM_EN
        ,
        .therm_o     (therm_o)
`endif
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Scoreboard monitor: every bit about to be accepted must match the
    // oldest queued expectation.
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_bit: got bit=%0b last=%0b, queue empty", out_bit, out_last);
            end else begin
                e = exp_q.pop_front();
                if ({out_bit, out_last} !== e) begin
                    failures++;
                    $display("[TB] FAIL stream_bit: got bit=%0b last=%0b, expected bit=%0b last=%0b",
                             out_bit, out_last, e[1], e[0]);
                end
            end
        end
    end

    // Queue the unary group expected for a count word.
    task automatic push_group(input int c);
        int k;
        k = (c > GROUP) ? GROUP : c;
        for (int i = 0; i < GROUP; i++) exp_q.push_back({(i < k) ? 1'b1 : 1'b0, (i == GROUP - 1) ? 1'b1 : 1'b0});
    endtask

    // Wait (bounded) until all expected bits are delivered and output idles.
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            if (exp_q.size() == 0 && out_valid === 1'b0) break;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_drain: left=%0d out_valid=%0b, expected left=0 out_valid=0", name, exp_q.size(), out_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_bit, out_last, err_illegal} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %b, expected 0000", {out_valid, out_bit, out_last, err_illegal});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
`ifdef CNT_EXPAND_THERM_EN
        checks++;
        if (therm_o !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL reset_therm: got %b, expected 00000", therm_o);
        end
`endif
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_count  = 3'd3;
        push_group(3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_bit} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL single_latency: got valid/bit=%b, expected 11", {out_valid, out_bit});
        end
        wait_drain("single");
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_count = 3'd5;
        push_group(5);
        @(posedge clk); #1;
        in_count = 3'd0;
        push_group(0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== (k == 4 || k == 9)) begin
                failures++;
                $display("[TB] FAIL b2b_cycle%0d: got valid=%b ready=%b, expected valid=1 ready=%b",
                         k, out_valid, in_ready, (k == 4 || k == 9));
            end
            @(posedge clk); #1;
            if (k == 4) in_valid = 1'b0;
        end
        wait_drain("b2b");
    endtask

    task automatic test_illegal();
        int vals[2] = '{7, 6};
        for (int v = 0; v < 2; v++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_count = CW'(vals[v]);
            push_group(vals[v]);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (err_illegal !== 1'b1) begin
                failures++;
                $display("[TB] FAIL illegal%0d_pulse: got %b, expected 1", vals[v], err_illegal);
            end
            @(negedge clk);
            checks++;
            if (err_illegal !== 1'b0) begin
                failures++;
                $display("[TB] FAIL illegal%0d_width: got %b, expected 0", vals[v], err_illegal);
            end
            wait_drain("illegal");
        end
    endtask

    task automatic test_stall();
        logic pat[8] = '{1, 0, 0, 1, 1, 0, 1, 1};
        logic prev_ready;
        logic [1:0] prev_out;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_count = 3'd2;
        push_group(2);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        prev_ready = 1'b1;
        prev_out   = 2'b00;
        for (int k = 0; k < 8; k++) begin
            out_ready = pat[k];
            @(negedge clk);
            if (!prev_ready) begin
                checks++;
                if ({out_bit, out_last} !== prev_out || out_valid !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL stall_hold%0d: got valid=%b bit/last=%b, expected valid=1 bit/last=%b",
                             k, out_valid, {out_bit, out_last}, prev_out);
                end
            end
            prev_ready = pat[k];
            prev_out   = {out_bit, out_last};
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_drain("stall");
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_count = 3'd4;
        push_group(4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_valid: got %b, expected 0", out_valid);
        end
        checks++;
        if (exp_q.size() != 3) begin
            failures++;
            $display("[TB] FAIL midreset_consumed: got %0d bits left, expected 3", exp_q.size());
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_release: got ready=%b valid=%b, expected ready=1 valid=0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_count = 3'd1;
        push_group(1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain("midreset");
    endtask

`ifdef CNT_EXPAND_THERM_EN
    task automatic test_therm();
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_count = 3'd4;
        push_group(4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (therm_o !== 5'b01111) begin
            failures++;
            $display("[TB] FAIL therm_load: got %b, expected 01111", therm_o);
        end
        wait_drain("therm");
        checks++;
        if (therm_o !== 5'b01111) begin
            failures++;
            $display("[TB] FAIL therm_hold: got %b, expected 01111", therm_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_illegal();
        test_stall();
        test_reset_mid();
`ifdef CNT_EXPAND_THERM_EN
        test_therm();
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_expander.md
Name: count_expander

Overview:
- Inverse of the 5:3 counter datapath: accepts a 3-bit ones-count word {cout,carry,sum} (weights 4,2,1; legal 0..5).
- Regenerates a canonical 5-bit unary group from each word and serializes it as one bit per beat, ones first, then zeros.
- Used to rebuild unary/thermometer streams for test-pattern regeneration and for loopback-checking compressor trees.
- Valid/ready handshake on both sides; zero-bubble back-to-back operation.

Parameters:
GROUP, 5, number of unary bits per count word (bits per output group).
CW, 3, count width; must be at least clog2(GROUP+1).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  count word offered
in_ready  output  1  block can accept a count word this cycle
in_count  input  CW  ones-count; bit2=cout, bit1=carry, bit0=sum
out_valid  output  1  out_bit is valid
out_ready  input  1  downstream accepts out_bit
out_bit  output  1  current unary bit
out_last  output  1  marks the final bit (index GROUP-1) of a group
err_illegal  output  1  one-cycle pulse: an accepted in_count was greater than GROUP

Behaviour:
- Reset (async assert, sync-release assumed upstream):
  - state=IDLE, idx=0, cnt_q=0.
  - out_valid=0, out_bit=0, out_last=0, err_illegal=0.
  - in_ready=1 once rst_n is high.
- Input acceptance: an input handshake occurs when in_valid and in_ready are both high at a clock edge.
- FSM states:
  - IDLE: out_valid=0, in_ready=1. On input handshake: cnt_q ← clamp(in_count), idx ← 0, go to EMIT.
  - EMIT: out_valid=1.
    - out_bit = (idx < cnt_q); out_last = (idx == GROUP-1).
    - On output handshake (out_valid & out_ready) with idx < GROUP-1: idx ← idx+1.
    - On output handshake with idx == GROUP-1: the group is finished.
      - If an input handshake occurs in the same cycle: reload cnt_q, idx ← 0, stay in EMIT.
      - Otherwise: go to IDLE.
- in_ready = (state==IDLE) | (state==EMIT & idx==GROUP-1 & out_ready). This is combinational from out_ready and gives zero bubbles between groups.
- Latency: the first bit of a group appears one cycle after its input handshake.
- Sustained throughput: one group per GROUP cycles when out_ready stays high.
- Stall: while out_ready=0, out_bit, out_last, idx and cnt_q hold; out_valid stays 1 and never drops mid-group.
- Illegal count (in_count > GROUP, e.g. 6 or 7):
  - Clamp to GROUP (all-ones group).
  - err_illegal pulses high for the single cycle after the accepting edge.
- Count 0: emits GROUP zeros. Count GROUP: emits GROUP ones.
- Reset mid-group: the group is discarded immediately; no partial completion after reset release.
- idx width is clog2(GROUP); idx never exceeds GROUP-1 (no wrap).

Optional Feature:
- Macro: CNT_EXPAND_THERM_EN.
- Defined:
  - Adds output port therm_o [GROUP-1:0], a registered thermometer of cnt_q (bit i = i < cnt_q).
  - Updated on every input handshake; reset value 0.
  - Holds its value through IDLE.
- Undefined: port and register are absent; serial behaviour is identical either way.

Decomposition:
- Package cnt_pkg holds:
  - GROUP_DEF=5 and CW_DEF=3.
  - State enum {IDLE, EMIT}.
  - A clamp function (count → min(count, GROUP)).
- One sub-module is natural: cnt_therm_dec.
  - Combinational; count in, GROUP-bit thermometer out.
  - out_bit is selected from it by idx; it also drives therm_o when enabled.

Test Plan:
- Reset, then in_count=3, out_ready held 1 → out_bit sequence 1,1,1,0,0 on cycles 1..5; out_last only on the 5th bit; then out_valid=0.
- Back-to-back words 5 then 0, in_valid held, out_ready=1 → 1,1,1,1,1,0,0,0,0,0 with no idle cycle; in_ready high only on the last-bit cycle.
- in_count=7 → err_illegal high for exactly one cycle; output 1,1,1,1,1. Repeat with 6 → same response.
- in_count=2 with out_ready toggling 1,0,0,1,1,0,1,1 → bits 1,1,0,0,0 delivered in order; out_bit/out_last stable during stalls.
- rst_n asserted mid-group (after 2 bits of count 4) → out_valid=0 immediately; after release, in_ready=1 and a new count 1 yields 1,0,0,0,0.
- With CNT_EXPAND_THERM_EN defined, in_count=4 → therm_o=5'b01111 one cycle after the handshake; it holds after the group completes.
